// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_control
//  Purpose  : Multi-cycle control FSM for the MIPS core. Sequences
//             FETCH / DECODE / EXEC / MEM / WB over a shared ALU and a unified
//             memory, stalls on the memory ready handshake, aborts accesses
//             that wait too long, and keeps retired-instruction and cycle
//             counters.
//  Ports    : clk_i, rst_i (async, active-high)
//             opcode_i, funct_i, mem_ready_i         - IR fields / memory ack
//             mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
//             RegWrite_o, PCWrite_o, PCWriteCond_o, PCWriteCondNe_o,
//             ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, RegDst_o,
//             MemtoReg_o                             - datapath controls
//             state_o                                - debug state encoding
//             illegal_o, mem_timeout_o               - sticky error flags
//             instr_count_o, cycle_count_o           - wrapping counters
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
    parameter int CNT_WIDTH  = 32,
    parameter int WAIT_LIMIT = 16,
    parameter int HAS_JAL    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [5:0]           opcode_i,
    input  logic [5:0]           funct_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 IorD_o,
    output logic                 MemRead_o,
    output logic                 MemWrite_o,
    output logic                 IRWrite_o,
    output logic                 RegWrite_o,
    output logic                 PCWrite_o,
    output logic                 PCWriteCond_o,
    output logic                 PCWriteCondNe_o,
    output logic                 ALUSrcA_o,
    output logic [1:0]           ALUSrcB_o,
    output logic [2:0]           ALUOp_o,
    output logic [1:0]           PCSource_o,
    output logic [1:0]           RegDst_o,
    output logic [1:0]           MemtoReg_o,
    output logic [3:0]           state_o,
    output logic                 illegal_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] instr_count_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_R_EX   = 4'd7,
        S_R_WB   = 4'd8,
        S_I_EX   = 4'd9,
        S_I_WB   = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Wait counter holds the number of non-ready cycles already spent in the
    // current memory state, so it only needs to reach WAIT_LIMIT-1.
    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT > 0) ? WAIT_W'(WAIT_LIMIT - 1) : '0;

    state_t                 state_q, state_d;
    logic [5:0]             opcode_q, opcode_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic                   retire;
    logic                   wait_expired;

    // funct is decoded by the downstream ALU control when ALUOp selects it.
    logic unused_funct;
    assign unused_funct = ^funct_i;

    // Last permitted non-ready cycle of an access; a ready in this cycle
    // still completes the access normally.
    assign wait_expired = (WAIT_LIMIT > 0) && (wait_q == WAIT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            wait_q        <= '0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            instr_count_q <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            wait_q        <= wait_d;
            illegal_q     <= illegal_d;
            timeout_q     <= timeout_d;
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Next-state logic. wait_d defaults to zero so every entry into a memory
    // state (including FETCH re-entered after a timeout) starts a fresh count.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                opcode_d = opcode_i;
                case (opcode_i)
                    OP_RTYPE:                         state_d = S_R_EX;
                    OP_LW, OP_SW:                     state_d = S_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BR;
                    OP_J:                             state_d = S_JMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EX;
                    OP_JAL: begin
                        if (HAS_JAL != 0) begin
                            state_d = S_JMP;
                        end else begin
                            illegal_d = 1'b1;
                            retire    = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: begin
                        // Undecodable opcodes retire as no-ops.
                        illegal_d = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_ADDR:   state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_R_EX:   state_d = S_R_WB;
            S_I_EX:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BR, S_JMP: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default:  state_d = S_IDLE;
        endcase

        instr_count_d = retire ? (instr_count_q + CNT_WIDTH'(1)) : instr_count_q;
        cycle_count_d = (state_q != S_IDLE) ? (cycle_count_q + CNT_WIDTH'(1)) : cycle_count_q;
    end

    // Moore output decode; the FETCH write enables are gated by the
    // handshake so IR and PC only update on the completing cycle.
    always_comb begin
        mem_req_o       = 1'b0;
        IorD_o          = 1'b0;
        MemRead_o       = 1'b0;
        MemWrite_o      = 1'b0;
        IRWrite_o       = 1'b0;
        RegWrite_o      = 1'b0;
        PCWrite_o       = 1'b0;
        PCWriteCond_o   = 1'b0;
        PCWriteCondNe_o = 1'b0;
        ALUSrcA_o       = 1'b0;
        ALUSrcB_o       = 2'b00;
        ALUOp_o         = 3'b000;
        PCSource_o      = 2'b00;
        RegDst_o        = 2'b00;
        MemtoReg_o      = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                MemRead_o = 1'b1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                ALUSrcB_o = 2'b01;
            end
            S_DECODE: ALUSrcB_o = 2'b11;
            S_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 2'b01;
            end
            S_MEM_WR: begin
                mem_req_o  = 1'b1;
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_R_EX: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 3'b010;
            end
            S_R_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 2'b01;
            end
            S_I_EX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                case (opcode_q)
                    OP_SLTI: ALUOp_o = 3'b101;
                    OP_ANDI: ALUOp_o = 3'b011;
                    OP_ORI:  ALUOp_o = 3'b100;
                    default: ALUOp_o = 3'b000;
                endcase
            end
            S_I_WB:   RegWrite_o = 1'b1;
            S_BR: begin
                ALUSrcA_o       = 1'b1;
                ALUOp_o         = 3'b001;
                PCSource_o      = 2'b01;
                PCWriteCond_o   = (opcode_q == OP_BEQ);
                PCWriteCondNe_o = (opcode_q == OP_BNE);
            end
            S_JMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                if (opcode_q == OP_JAL) begin
                    RegWrite_o = 1'b1;
                    RegDst_o   = 2'b10;
                    MemtoReg_o = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign state_o       = state_q;
    assign illegal_o     = illegal_q;
    assign mem_timeout_o = timeout_q;
    assign instr_count_o = instr_count_q;
    assign cycle_count_o = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mips_mc_control
//  Purpose  : Self-checking bench for mips_mc_control. Instance A uses the
//             default parameters; instance B uses CNT_WIDTH=4, WAIT_LIMIT=4,
//             HAS_JAL=0. Expected per-cycle control vectors are built from
//             the instruction class and the chosen memory delays.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rdy_a, rdy_b;
    logic [5:0] op_a, op_b, fn_a, fn_b;

    logic a_req, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_pcw, a_pcc, a_pcn, a_sa, a_ill, a_to;
    logic [1:0] a_sb, a_pcs, a_rd, a_m2r;
    logic [2:0] a_aop;
    logic [3:0] a_state;
    logic [31:0] a_icnt, a_ccnt;

    logic b_req, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_pcw, b_pcc, b_pcn, b_sa, b_ill, b_to;
    logic [1:0] b_sb, b_pcs, b_rd, b_m2r;
    logic [2:0] b_aop;
    logic [3:0] b_state;
    logic [3:0] b_icnt, b_ccnt;

    mips_mc_control #(.CNT_WIDTH(32), .WAIT_LIMIT(16), .HAS_JAL(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .opcode_i(op_a), .funct_i(fn_a), .mem_ready_i(rdy_a),
        .mem_req_o(a_req), .IorD_o(a_iord), .MemRead_o(a_mrd), .MemWrite_o(a_mwr),
        .IRWrite_o(a_irw), .RegWrite_o(a_rw), .PCWrite_o(a_pcw), .PCWriteCond_o(a_pcc),
        .PCWriteCondNe_o(a_pcn), .ALUSrcA_o(a_sa), .ALUSrcB_o(a_sb), .ALUOp_o(a_aop),
        .PCSource_o(a_pcs), .RegDst_o(a_rd), .MemtoReg_o(a_m2r), .state_o(a_state),
        .illegal_o(a_ill), .mem_timeout_o(a_to), .instr_count_o(a_icnt), .cycle_count_o(a_ccnt)
    );

    mips_mc_control #(.CNT_WIDTH(4), .WAIT_LIMIT(4), .HAS_JAL(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .opcode_i(op_b), .funct_i(fn_b), .mem_ready_i(rdy_b),
        .mem_req_o(b_req), .IorD_o(b_iord), .MemRead_o(b_mrd), .MemWrite_o(b_mwr),
        .IRWrite_o(b_irw), .RegWrite_o(b_rw), .PCWrite_o(b_pcw), .PCWriteCond_o(b_pcc),
        .PCWriteCondNe_o(b_pcn), .ALUSrcA_o(b_sa), .ALUSrcB_o(b_sb), .ALUOp_o(b_aop),
        .PCSource_o(b_pcs), .RegDst_o(b_rd), .MemtoReg_o(b_m2r), .state_o(b_state),
        .illegal_o(b_ill), .mem_timeout_o(b_to), .instr_count_o(b_icnt), .cycle_count_o(b_ccnt)
    );

    // Control vector field order:
    // {mem_req, IorD, MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond,
    //  PCWriteCondNe, ALUSrcA, ALUSrcB[2], ALUOp[3], PCSource[2], RegDst[2], MemtoReg[2]}
    logic [20:0] va, vb;
    assign va = {a_req, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_pcw, a_pcc, a_pcn, a_sa,
                 a_sb, a_aop, a_pcs, a_rd, a_m2r};
    assign vb = {b_req, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_pcw, b_pcc, b_pcn, b_sa,
                 b_sb, b_aop, b_pcs, b_rd, b_m2r};

    function automatic logic [20:0] cv(input logic req, iord, mrd, mwr, irw, rw, pcw, pcc, pcn, sa,
                                       input logic [1:0] sb, input logic [2:0] aop,
                                       input logic [1:0] pcs, rd, m2r);
        return {req, iord, mrd, mwr, irw, rw, pcw, pcc, pcn, sa, sb, aop, pcs, rd, m2r};
    endfunction

    logic [20:0] V_FETCH_W, V_FETCH_R, V_DEC;
    initial begin
        V_FETCH_W = cv(1,0,1,0,0,0,0,0,0,0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00);
        V_FETCH_R = cv(1,0,1,0,1,0,1,0,0,0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00);
        V_DEC     = cv(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b000, 2'b00, 2'b00, 2'b00);
    end

    int errors = 0;
    int checks = 0;
    int unsigned m_instr;
    int unsigned m_cycles;
    bit m_illegal;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction on instance A starting in FETCH, comparing every
    // cycle against a trace built from the instruction class and delays.
    task automatic run_instr(input logic [5:0] op, input int fd, input int md);
        logic [20:0] exp_q[$];
        logic        rdy_q[$];
        int          dec_idx;
        bit          bad;
        logic [2:0]  iop;

        checks++;
        if (a_icnt !== m_instr) begin
            errors++; $display("FAIL instr_count_a: got %0d want %0d", a_icnt, m_instr);
        end
        checks++;
        if (a_ccnt !== m_cycles) begin
            errors++; $display("FAIL cycle_count_a: got %0d want %0d", a_ccnt, m_cycles);
        end
        checks++;
        if (a_ill !== m_illegal || a_to !== 1'b0) begin
            errors++; $display("FAIL flags_a: got ill=%b to=%b want ill=%b to=0", a_ill, a_to, m_illegal);
        end

        for (int k = 0; k < fd; k++) begin exp_q.push_back(V_FETCH_W); rdy_q.push_back(1'b0); end
        exp_q.push_back(V_FETCH_R); rdy_q.push_back(1'b1);
        dec_idx = exp_q.size();
        exp_q.push_back(V_DEC); rdy_q.push_back(1'($urandom));
        bad = 1'b0;
        case (op)
            6'h00: begin
                exp_q.push_back(cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00));
                exp_q.push_back(cv(0,0,0,0,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00));
                rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                iop = (op == 6'h0A) ? 3'b101 : (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
                exp_q.push_back(cv(0,0,0,0,0,0,0,0,0,1, 2'b10, iop, 2'b00, 2'b00, 2'b00));
                exp_q.push_back(cv(0,0,0,0,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00));
                rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
            end
            6'h23, 6'h2B: begin
                exp_q.push_back(cv(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00));
                rdy_q.push_back(1'($urandom));
                for (int k = 0; k <= md; k++) begin
                    exp_q.push_back(cv(1,1,(op == 6'h23),(op == 6'h2B),0,0,0,0,0,0,
                                       2'b00, 3'b000, 2'b00, 2'b00, 2'b00));
                    rdy_q.push_back(k == md);
                end
                if (op == 6'h23) begin
                    exp_q.push_back(cv(0,0,0,0,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01));
                    rdy_q.push_back(1'($urandom));
                end
            end
            6'h04, 6'h05: begin
                exp_q.push_back(cv(0,0,0,0,0,0,0,(op == 6'h04),(op == 6'h05),1,
                                   2'b00, 3'b001, 2'b01, 2'b00, 2'b00));
                rdy_q.push_back(1'($urandom));
            end
            6'h02: begin
                exp_q.push_back(cv(0,0,0,0,0,0,1,0,0,0, 2'b00, 3'b000, 2'b10, 2'b00, 2'b00));
                rdy_q.push_back(1'($urandom));
            end
            6'h03: begin
                exp_q.push_back(cv(0,0,0,0,0,1,1,0,0,0, 2'b00, 3'b000, 2'b10, 2'b10, 2'b10));
                rdy_q.push_back(1'($urandom));
            end
            default: bad = 1'b1;
        endcase

        foreach (exp_q[i]) begin
            op_a  = (i == dec_idx) ? op : 6'($urandom);
            fn_a  = 6'($urandom);
            rdy_a = rdy_q[i];
            #1;
            checks++;
            if (va !== exp_q[i]) begin
                errors++;
                $display("FAIL ctl_a op=%02h cyc=%0d: got %06h want %06h", op, i, va, exp_q[i]);
            end
            tick();
        end
        m_cycles += exp_q.size();
        m_instr++;
        if (bad) m_illegal = 1'b1;
    endtask

    task automatic release_a();
        @(posedge clk); #1;
        rst_a = 1'b0; rdy_a = 1'b1; #1;
        checks++;
        if (va !== 21'd0 || a_icnt !== 0 || a_ccnt !== 0 || a_ill !== 0 || a_to !== 0) begin
            errors++; $display("FAIL idle_a: got vec=%06h ic=%0d cc=%0d want all 0", va, a_icnt, a_ccnt);
        end
        tick();
        m_instr = 0; m_cycles = 0; m_illegal = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        op_a = 6'h00; op_b = 6'h00; fn_a = 6'h20; fn_b = 6'h20;
        tick(); tick();
        checks++;
        if (va !== 21'd0 || a_icnt !== 0 || a_ccnt !== 0 || a_ill !== 0 || a_to !== 0) begin
            errors++; $display("FAIL reset_a: got vec=%06h ic=%0d cc=%0d want all 0", va, a_icnt, a_ccnt);
        end
        checks++;
        if (vb !== 21'd0 || b_icnt !== 0 || b_ccnt !== 0 || b_ill !== 0 || b_to !== 0) begin
            errors++; $display("FAIL reset_b: got vec=%06h ic=%0d cc=%0d want all 0", vb, b_icnt, b_ccnt);
        end
        release_a();
    endtask

    task automatic test_add();
        run_instr(6'h00, 0, 0);
        checks++;
        if (a_icnt !== 32'd1 || a_ccnt !== 32'd4) begin
            errors++; $display("FAIL add_counts: got ic=%0d cc=%0d want 1/4", a_icnt, a_ccnt);
        end
    endtask

    task automatic test_lw_stall();
        int unsigned c0;
        c0 = a_ccnt;
        run_instr(6'h23, 2, 2);
        checks++;
        if (a_ccnt - c0 !== 32'd9) begin
            errors++; $display("FAIL lw_latency: got %0d want 9", a_ccnt - c0);
        end
    endtask

    task automatic test_branch_jump();
        run_instr(6'h05, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h03, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h2B, 0, 3);
        run_instr(6'h3F, 0, 0);
        checks++;
        if (a_ill !== 1'b1) begin
            errors++; $display("FAIL illegal_a: got %b want 1", a_ill);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [13] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                                 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h01, 6'h20};
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(12)], $urandom_range(3), $urandom_range(3));
    endtask

    task automatic test_reset_mid_mem();
        rdy_a = 1'b1; op_a = 6'h23; tick();          // -> DECODE
        op_a = 6'h23; tick();                        // -> ADDR
        tick();                                      // -> MEM_RD
        rdy_a = 1'b0; op_a = 6'h00; #1;
        checks++;
        if (va !== cv(1,1,1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00)) begin
            errors++; $display("FAIL mem_rd_a: got %06h", va);
        end
        rst_a = 1'b1; #1;
        checks++;
        if (va !== 21'd0 || a_icnt !== 0 || a_ccnt !== 0 || a_ill !== 0) begin
            errors++; $display("FAIL async_reset_a: got vec=%06h ic=%0d cc=%0d want 0", va, a_icnt, a_ccnt);
        end
        release_a();
        run_instr(6'h0D, 1, 0);
        run_instr(6'h00, 0, 0);
    endtask

    task automatic test_jal_illegal_b();
        @(posedge clk); #1;
        rst_b = 1'b0; rdy_b = 1'b1; op_b = 6'h00; #1;
        checks++;
        if (vb !== 21'd0) begin errors++; $display("FAIL idle_b: got %06h want 0", vb); end
        tick();                                     // FETCH
        #1;
        checks++;
        if (vb !== V_FETCH_R || b_ill !== 1'b0) begin
            errors++; $display("FAIL fetch_b: got %06h ill=%b", vb, b_ill);
        end
        tick();                                     // DECODE
        op_b = 6'h03; #1;
        checks++;
        if (vb !== V_DEC) begin errors++; $display("FAIL dec_b: got %06h want %06h", vb, V_DEC); end
        tick();                                     // jal illegal -> FETCH
        rdy_b = 1'b0; op_b = 6'h02; #1;
        checks++;
        if (vb !== V_FETCH_W || b_ill !== 1'b1 || b_icnt !== 4'd1) begin
            errors++; $display("FAIL jal_illegal_b: got %06h ill=%b ic=%0d want %06h 1 1", vb, b_ill, b_icnt, V_FETCH_W);
        end
        rdy_b = 1'b1; tick();                       // DECODE
        op_b = 6'h3F; tick();                       // -> FETCH
        rdy_b = 1'b0; #1;
        checks++;
        if (vb !== V_FETCH_W || b_icnt !== 4'd2) begin
            errors++; $display("FAIL op3f_b: got %06h ic=%0d want %06h 2", vb, b_icnt, V_FETCH_W);
        end
    endtask

    task automatic test_timeout_b();
        rdy_b = 1'b1; tick();                       // DECODE
        op_b = 6'h2B; tick();                       // ADDR
        tick();                                     // MEM_WR
        rdy_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (vb !== cv(1,1,0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00) || b_to !== 1'b0) begin
                errors++; $display("FAIL sw_wait_b k=%0d: got %06h to=%b", k, vb, b_to);
            end
            tick();
        end
        #1;
        checks++;
        if (vb !== V_FETCH_W || b_to !== 1'b1 || b_icnt !== 4'd2) begin
            errors++; $display("FAIL timeout_b: got %06h to=%b ic=%0d want %06h 1 2", vb, b_to, b_icnt, V_FETCH_W);
        end
        tick(); #1;
        tick(); #1;
        checks++;
        if (vb !== V_FETCH_W) begin errors++; $display("FAIL fetch_wait3_b: got %06h", vb); end
        tick();
        rdy_b = 1'b1; #1;                           // ready on the limit cycle
        checks++;
        if (vb !== V_FETCH_R) begin errors++; $display("FAIL limit_ready_b: got %06h want %06h", vb, V_FETCH_R); end
        tick();
        op_b = 6'h00; #1;
        checks++;
        if (vb !== V_DEC) begin errors++; $display("FAIL limit_dec_b: got %06h want %06h", vb, V_DEC); end
        tick(); tick(); tick();
        checks++;
        if (b_icnt !== 4'd3) begin errors++; $display("FAIL post_limit_ic_b: got %0d want 3", b_icnt); end
    endtask

    task automatic test_wrap_b();
        rst_b = 1'b1; #1;
        @(posedge clk); #1;
        rst_b = 1'b0; rdy_b = 1'b1; op_b = 6'h00;
        tick();                                     // FETCH
        for (int n = 1; n <= 16; n++) begin
            tick(); tick(); tick(); tick();
            checks++;
            if (b_icnt !== 4'(n) || b_ccnt !== 4'(4 * n)) begin
                errors++; $display("FAIL wrap_b n=%0d: got ic=%0d cc=%0d want %0d %0d",
                                   n, b_icnt, b_ccnt, 4'(n), 4'(4 * n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch_jump();
        test_random();
        test_reset_mid_mem();
        test_jal_illegal_b();
        test_timeout_b();
        test_wrap_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
